// File: rtl/control_pipeline_pkg.sv
// Shared widths, forwarding encodings and pipeline-register layouts for control_pipeline.
package control_pipeline_pkg;

  localparam int ALUOP_W = 3;
  localparam int REG_W   = 5;

  typedef logic [REG_W-1:0] reg_idx_t;

  // EX operand source: register file, EX/MEM result, or MEM/WB result.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  // ID/EX keeps every decoded bit plus the register fields used by hazard and forwarding logic.
  typedef struct packed {
    logic               valid;
    logic               reg_dst;
    logic               alu_src;
    logic               mem_to_reg;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               branch;
    logic [ALUOP_W-1:0] alu_op;
    reg_idx_t           rs;
    reg_idx_t           rt;
    reg_idx_t           rd;
  } id_ex_t;

  // EX/MEM keeps only what the memory and write-back stages still need.
  typedef struct packed {
    logic     valid;
    logic     mem_read;
    logic     mem_write;
    logic     branch;
    logic     reg_write;
    logic     mem_to_reg;
    reg_idx_t wreg;
  } ex_mem_t;

  typedef struct packed {
    logic     valid;
    logic     reg_write;
    logic     mem_to_reg;
    reg_idx_t wreg;
  } mem_wb_t;

  // True when an older stage will write the register an EX operand reads; r0 never counts.
  function automatic logic writer_matches(input logic valid, input logic reg_write,
                                          input reg_idx_t wreg, input reg_idx_t src);
    return valid && reg_write && (wreg != '0) && (wreg == src);
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding select for both EX operands; the younger EX/MEM result wins over MEM/WB.
module fwd_unit
  import control_pipeline_pkg::*;
(
  input  logic     [REG_W-1:0] ex_rs_i,
  input  logic     [REG_W-1:0] ex_rt_i,
  input  logic                 mem_valid_i,
  input  logic                 mem_reg_write_i,
  input  logic     [REG_W-1:0] mem_wreg_i,
  input  logic                 wb_valid_i,
  input  logic                 wb_reg_write_i,
  input  logic     [REG_W-1:0] wb_wreg_i,
  output fwd_sel_t             fwd_a_o,
  output fwd_sel_t             fwd_b_o
);

  // Same priority test applied independently to rs and rt.
  always_comb begin
    fwd_a_o = FWD_RF;
    fwd_b_o = FWD_RF;
    if (writer_matches(mem_valid_i, mem_reg_write_i, mem_wreg_i, ex_rs_i)) begin
      fwd_a_o = FWD_MEM;
    end else if (writer_matches(wb_valid_i, wb_reg_write_i, wb_wreg_i, ex_rs_i)) begin
      fwd_a_o = FWD_WB;
    end
    if (writer_matches(mem_valid_i, mem_reg_write_i, mem_wreg_i, ex_rt_i)) begin
      fwd_b_o = FWD_MEM;
    end else if (writer_matches(wb_valid_i, wb_reg_write_i, wb_wreg_i, ex_rt_i)) begin
      fwd_b_o = FWD_WB;
    end
  end

endmodule

// File: rtl/control_pipeline.sv
// Control-side ID/EX, EX/MEM, MEM/WB registers with load-use stall, flush, external freeze
// and operand forwarding selection.
module control_pipeline
  import control_pipeline_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic               id_RegDst,
  input  logic               id_ALUSrc,
  input  logic               id_MemtoReg,
  input  logic               id_RegWrite,
  input  logic               id_MemRead,
  input  logic               id_MemWrite,
  input  logic               id_Branch,
  input  logic [ALUOP_W-1:0] id_ALUOp,
  input  logic [REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]   id_rt,
  input  logic [REG_W-1:0]   id_rd,
  input  logic               ext_stall,
  input  logic               flush,
  output logic               ex_valid,
  output logic               ex_ALUSrc,
  output logic [ALUOP_W-1:0] ex_ALUOp,
  output logic [REG_W-1:0]   ex_wreg,
  output logic               mem_valid,
  output logic               mem_MemRead,
  output logic               mem_MemWrite,
  output logic               mem_Branch,
  output logic               mem_RegWrite,
  output logic [REG_W-1:0]   mem_wreg,
  output logic               wb_RegWrite,
  output logic               wb_MemtoReg,
  output logic [REG_W-1:0]   wb_wreg,
  output logic               hz_stall,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b
);

  id_ex_t   id_ex_q, id_ex_d, id_ex_in;
  ex_mem_t  ex_mem_q, ex_mem_d, ex_mem_in;
  mem_wb_t  mem_wb_q, mem_wb_d, mem_wb_in;
  fwd_sel_t fwd_a_sel, fwd_b_sel;

  // Pack the ID-stage instruction; an empty ID slot enters as a clean bubble.
  always_comb begin
    id_ex_in = '0;
    if (id_valid) begin
      id_ex_in.valid      = 1'b1;
      id_ex_in.reg_dst    = id_RegDst;
      id_ex_in.alu_src    = id_ALUSrc;
      id_ex_in.mem_to_reg = id_MemtoReg;
      id_ex_in.reg_write  = id_RegWrite;
      id_ex_in.mem_read   = id_MemRead;
      id_ex_in.mem_write  = id_MemWrite;
      id_ex_in.branch     = id_Branch;
      id_ex_in.alu_op     = id_ALUOp;
      id_ex_in.rs         = id_rs;
      id_ex_in.rt         = id_rt;
      id_ex_in.rd         = id_rd;
    end
  end

  assign ex_wreg = id_ex_q.reg_dst ? id_ex_q.rd : id_ex_q.rt;

  // A load in EX whose target feeds the ID instruction must be held back one cycle.
  assign hz_stall = id_valid && id_ex_q.valid && id_ex_q.mem_read && (id_ex_q.rt != '0) &&
                    ((id_ex_q.rt == id_rs) || (id_ex_q.rt == id_rt));

  assign ex_mem_in = '{valid:      id_ex_q.valid,
                       mem_read:   id_ex_q.mem_read,
                       mem_write:  id_ex_q.mem_write,
                       branch:     id_ex_q.branch,
                       reg_write:  id_ex_q.reg_write,
                       mem_to_reg: id_ex_q.mem_to_reg,
                       wreg:       ex_wreg};

  assign mem_wb_in = '{valid:      ex_mem_q.valid,
                       reg_write:  ex_mem_q.reg_write,
                       mem_to_reg: ex_mem_q.mem_to_reg,
                       wreg:       ex_mem_q.wreg};

  // Next-state selection: external freeze beats flush, flush beats load-use stall.
  always_comb begin
    // NOTE: hold is assigned to every target before the priority chain, so no path leaves one unassigned and no latch is inferred.
    id_ex_d  = id_ex_q;
    ex_mem_d = ex_mem_q;
    mem_wb_d = mem_wb_q;
    if (!ext_stall) begin
      mem_wb_d = mem_wb_in;
      if (flush) begin
        id_ex_d  = '0;
        ex_mem_d = '0;
      end else if (hz_stall) begin
        id_ex_d  = '0;
        ex_mem_d = ex_mem_in;
      end else begin
        id_ex_d  = id_ex_in;
        ex_mem_d = ex_mem_in;
      end
    end
  end

  // Pipeline registers; reset turns every stage into a bubble regardless of stall or flush.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments let all three stages sample pre-edge values and shift together.
    if (rst) begin
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  fwd_unit u_fwd (
    .ex_rs_i         (id_ex_q.rs),
    .ex_rt_i         (id_ex_q.rt),
    .mem_valid_i     (ex_mem_q.valid),
    .mem_reg_write_i (ex_mem_q.reg_write),
    .mem_wreg_i      (ex_mem_q.wreg),
    .wb_valid_i      (mem_wb_q.valid),
    .wb_reg_write_i  (mem_wb_q.reg_write),
    .wb_wreg_i       (mem_wb_q.wreg),
    .fwd_a_o         (fwd_a_sel),
    .fwd_b_o         (fwd_b_sel)
  );

  assign fwd_a        = fwd_a_sel;
  assign fwd_b        = fwd_b_sel;

  assign ex_valid     = id_ex_q.valid;
  assign ex_ALUSrc    = id_ex_q.alu_src;
  assign ex_ALUOp     = id_ex_q.alu_op;

  assign mem_valid    = ex_mem_q.valid;
  assign mem_MemRead  = ex_mem_q.mem_read;
  assign mem_MemWrite = ex_mem_q.mem_write;
  assign mem_Branch   = ex_mem_q.branch;
  assign mem_RegWrite = ex_mem_q.valid && ex_mem_q.reg_write;
  assign mem_wreg     = ex_mem_q.wreg;

  assign wb_RegWrite  = mem_wb_q.valid && mem_wb_q.reg_write;
  assign wb_MemtoReg  = mem_wb_q.mem_to_reg;
  assign wb_wreg      = mem_wb_q.wreg;

endmodule
